stream_demux_1to4: RTL and testbench

- Packet-aware 1:4 stream demultiplexer; the distribution-side counterpart of the 4:1 multiplexers in the multiplexer library.
- Routes one valid/ready input stream to one of four output streams, chosen by a 2-bit select.
- The select is latched on the first beat of a packet and held until the last beat.
- Each output has a one-entry registered stage. Sits between a single producer and four independent consumers.

---
 rtl/stream_demux_1to4.sv | 156 +++++++++++++++
 tb/tb_stream_demux_1to4.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1to4.sv
// stream_demux_1to4: packet-aware 1:4 valid/ready demultiplexer.
// The destination is taken from sel on the first beat of a packet and held
// until the last beat is accepted. Each output lane owns a one-entry
// registered stage and a completed-packet counter.

// One output lane: a single-entry register slice plus a packet counter.
module stream_demux_lane #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_last,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic [CNT_W-1:0] pkt_cnt
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fire;

   assign fire = valid_q & out_ready;

   // Load on write (which may coincide with a drain), else clear on drain.
   // Data and last only change on a write, so they stay put while stalled.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      if (wr_en) begin
         valid_d = 1'b1;
         data_d  = wr_data;
         last_d  = wr_last;
      end else if (fire) begin
         valid_d = 1'b0;
      end
      if (fire & last_q)
         cnt_d = cnt_q + 1'b1;
   end

   // Lane state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_last  = last_q;
   assign pkt_cnt   = cnt_q;

endmodule

module stream_demux_1to4 #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   input  logic [1:0]         sel,
   output logic [4*WIDTH-1:0] out_data,
   output logic [3:0]         out_valid,
   output logic [3:0]         out_last,
   input  logic [3:0]         out_ready,
   output logic               busy,
   output logic [1:0]         lock_sel,
   output logic [4*CNT_W-1:0] pkt_cnt
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] lock_sel_q, lock_sel_d;
   logic [1:0] target;
   logic       accept;
   logic [3:0] wr_en;

   // Target is live sel between packets, the latched lane inside one.
   // in_ready looks only at the target lane so a stalled lane elsewhere
   // never throttles the input, and a draining target can refill at once.
   always_comb begin
      target   = (state_q == LOCKED) ? lock_sel_q : sel;
      in_ready = ~out_valid[target] | out_ready[target];
      accept   = in_valid & in_ready;
      wr_en    = accept ? (4'b0001 << target) : 4'b0000;
   end

   // Packet framing: a non-last beat from IDLE locks the lane; any last beat
   // returns to IDLE. lock_sel also records single-beat destinations.
   always_comb begin
      state_d    = state_q;
      lock_sel_d = lock_sel_q;
      if (accept) begin
         if (state_q == IDLE)
            lock_sel_d = sel;
         state_d = in_last ? IDLE : LOCKED;
      end
   end

   // Framing state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         lock_sel_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         lock_sel_q <= lock_sel_d;
      end
   end

   assign busy     = (state_q == LOCKED);
   assign lock_sel = lock_sel_q;

   for (genvar k = 0; k < 4; k++) begin : g_lane
      stream_demux_lane #(
         .WIDTH (WIDTH),
         .CNT_W (CNT_W)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .wr_en     (wr_en[k]),
         .wr_data   (in_data),
         .wr_last   (in_last),
         .out_ready (out_ready[k]),
         .out_valid (out_valid[k]),
         .out_data  (out_data[k*WIDTH +: WIDTH]),
         .out_last  (out_last[k]),
         .pkt_cnt   (pkt_cnt[k*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Scoreboard bench for stream_demux_1to4: the driver pushes each accepted
// beat onto its lane queue, a negedge monitor pops on every output handshake.
module tb_stream_demux_1to4;

   localparam int WIDTH = 8;
   localparam int CNT_W = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [WIDTH-1:0]   in_data = '0;
   logic               in_valid = 1'b0;
   logic               in_last = 1'b0;
   logic               in_ready;
   logic [1:0]         sel = 2'd0;
   logic [4*WIDTH-1:0] out_data;
   logic [3:0]         out_valid;
   logic [3:0]         out_last;
   logic [3:0]         out_ready = 4'b1111;
   logic               busy;
   logic [1:0]         lock_sel;
   logic [4*CNT_W-1:0] pkt_cnt;

   int checks = 0;
   int failures = 0;

   logic [WIDTH:0] exp_q [4][$];

   stream_demux_1to4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy),
      .lock_sel  (lock_sel),
      .pkt_cnt   (pkt_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   // Monitor: a beat leaves on the next posedge whenever valid&ready at negedge.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 4; k++) begin
            if (out_valid[k] && out_ready[k]) begin
               if (exp_q[k].size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_beat lane=%0d got=%0h exp=none", k, out_data[k*WIDTH +: WIDTH]);
               end else begin
                  logic [WIDTH:0] e;
                  e = exp_q[k].pop_front();
                  check($sformatf("lane%0d_data", k), 32'(out_data[k*WIDTH +: WIDTH]), 32'(e[WIDTH-1:0]));
                  check($sformatf("lane%0d_last", k), 32'(out_last[k]), 32'(e[WIDTH]));
               end
            end
         end
      end
   end

   // Present a beat (inputs settle at posedge+1).
   task automatic drive(input logic [1:0] s, input logic [WIDTH-1:0] d, input logic l);
      sel = s; in_data = d; in_last = l; in_valid = 1'b1;
   endtask

   // Wait for the held beat to be accepted, then record it for its lane.
   task automatic wait_accept(input int lane);
      int n = 0;
      #1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) begin
         checks++; failures++;
         $display("FAIL accept_timeout got=in_ready_low exp=accept lane=%0d", lane);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      exp_q[lane].push_back({in_last, in_data});
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input int lane, input logic [1:0] s, input logic [WIDTH-1:0] d, input logic l);
      drive(s, d, l);
      wait_accept(lane);
   endtask

   task automatic drain();
      out_ready = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      // Reset state
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_lock_sel", 32'(lock_sel), 32'h0);
      check("rst_pkt_cnt", pkt_cnt, 32'h0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      // Single-beat packet to lane2
      send(2, 2'd2, 8'hA5, 1'b1);
      check("t1_out_valid", 32'(out_valid), 32'h4);
      check("t1_lane2_data", 32'(out_data[2*WIDTH +: WIDTH]), 32'hA5);
      check("t1_busy", 32'(busy), 32'h0);
      check("t1_lock_sel", 32'(lock_sel), 32'h2);
      drain();
      check("t1_pkt_cnt2", 32'(pkt_cnt[2*CNT_W +: CNT_W]), 32'h1);

      // 3-beat packet to lane1; sel moves to 3 after beat 1 and is ignored
      send(1, 2'd1, 8'h11, 1'b0);
      check("t2_busy_b1", 32'(busy), 32'h1);
      send(1, 2'd3, 8'h22, 1'b0);
      check("t2_busy_b2", 32'(busy), 32'h1);
      send(1, 2'd3, 8'h33, 1'b1);
      check("t2_busy_b3", 32'(busy), 32'h0);
      check("t2_lock_sel", 32'(lock_sel), 32'h1);
      drain();
      check("t2_pkt_cnt1", 32'(pkt_cnt[1*CNT_W +: CNT_W]), 32'h1);

      // Lane0 backpressure during a 2-beat packet, then no-bubble refill
      out_ready = 4'b1110;
      send(0, 2'd0, 8'h44, 1'b0);
      drive(2'd0, 8'h55, 1'b1);
      #1;
      check("t3_in_ready_stall", 32'(in_ready), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("t3_hold_valid", 32'(out_valid[0]), 32'h1);
      check("t3_hold_data", 32'(out_data[7:0]), 32'h44);
      out_ready = 4'b1111;
      wait_accept(0);
      check("t3_nobubble_valid", 32'(out_valid[0]), 32'h1);
      check("t3_nobubble_data", 32'(out_data[7:0]), 32'h55);
      drain();
      check("t3_pkt_cnt0", 32'(pkt_cnt[0 +: CNT_W]), 32'h1);

      // Lane3 stalled with a beat while a full-rate packet goes to lane2
      out_ready = 4'b0111;
      send(3, 2'd3, 8'h77, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(2'd2, 8'(8'h90 + i), (i == 2));
         #1;
         check("t4_in_ready", 32'(in_ready), 32'h1);
         @(posedge clk);
         exp_q[2].push_back({in_last, in_data});
         #1;
      end
      in_valid = 1'b0;
      check("t4_lane3_valid", 32'(out_valid[3]), 32'h1);
      check("t4_lane3_data", 32'(out_data[3*WIDTH +: WIDTH]), 32'h77);
      repeat (2) @(posedge clk);
      #1;
      check("t4_lane3_still", 32'(out_data[3*WIDTH +: WIDTH]), 32'h77);
      drain();
      check("t4_pkt_cnt_all", pkt_cnt, 32'h01020101);

      // Asynchronous reset in the middle of a 4-beat packet to lane3
      send(3, 2'd3, 8'hC1, 1'b0);
      send(3, 2'd3, 8'hC2, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("t6_busy_mid", 32'(busy), 32'h1);
      check("t6_lock_mid", 32'(lock_sel), 32'h3);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(out_valid), 32'h0);
      check("t6_rst_data", out_data, 32'h0);
      check("t6_rst_busy", 32'(busy), 32'h0);
      check("t6_rst_lock", 32'(lock_sel), 32'h0);
      check("t6_rst_cnt", pkt_cnt, 32'h0);
      for (int k = 0; k < 4; k++) exp_q[k].delete();
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      send(0, 2'd0, 8'h5A, 1'b1);
      check("t6_post_valid", 32'(out_valid), 32'h1);
      check("t6_post_data", 32'(out_data[7:0]), 32'h5A);
      drain();
      check("t6_post_cnt", pkt_cnt, 32'h00000001);

      // Counter wrap on lane1: 255 then 256 packets
      for (int i = 0; i < 255; i++) send(1, 2'd1, 8'(i), 1'b1);
      drain();
      check("t5_cnt_255", 32'(pkt_cnt[1*CNT_W +: CNT_W]), 32'hFF);
      send(1, 2'd1, 8'hEE, 1'b1);
      drain();
      check("t5_cnt_wrap", 32'(pkt_cnt[1*CNT_W +: CNT_W]), 32'h0);

      // Every pushed beat must have been seen
      for (int k = 0; k < 4; k++)
         check($sformatf("lane%0d_queue_left", k), 32'(exp_q[k].size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
